conv_window_ctrl: RTL and testbench
===================================

Name: conv_window_ctrl

Overview:
Sequencer for the 3x3 convolution window shift register. Accepts a raster-order pixel stream with a valid/ready handshake and generates the shift enable and pixel feed for the shift register. Tracks row and column position and flags each cycle where the nine window taps hold a complete, non-wrapping KxK window. Sits between the image/feature-map reader and the conv MAC array, and emits per-frame completion.

Parameters:
DATA_W, 9, pixel width; matches the shift register WIDTH.
IMG_W, 8, image width in pixels; must be >= K.
IMG_H, 8, image height in rows; must be >= K.
K, 3, kernel size.
CW, $clog2(IMG_W), column counter width.
RW, $clog2(IMG_H), row counter width.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; arms a new frame when idle.
in_valid  in  1  input pixel valid.
in_ready  out  1  controller can accept a pixel.
in_data  in  DATA_W  input pixel.
shift_en  out  1  shift register advance; combinational, equals in_valid & in_ready.
pix_out  out  DATA_W  pixel to the shift register data_in; combinational pass-through of in_data.
win_valid  out  1  window taps are valid this cycle.
out_ready  in  1  downstream accepts window; used only with WIN_STALL_EN.
win_row  out  RW  top-left row of the current window.
win_col  out  CW  top-left column of the current window.
busy  out  1  high in FILL or RUN.
frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, row=col=0. win_valid, win_row, win_col and frame_done are all 0. in_ready=0, so shift_en=0. Reset mid-frame abandons the frame with no frame_done.
- States: IDLE, FILL, RUN, DONE.
  - IDLE: start=1 moves to FILL and clears row/col. start in any other state is ignored.
  - FILL: accepts pixels until the accepted pixel is (row=K-1, col=K-1), then moves to RUN.
  - RUN: accepts pixels until the accepted pixel is (IMG_H-1, IMG_W-1), then moves to DONE.
  - DONE: lasts one cycle with frame_done=1, then returns to IDLE.
- in_ready = (state is FILL or RUN) and not stalled.
- Accept = in_valid & in_ready. Only an accept advances counters and the shift register. in_valid gaps are allowed and freeze everything.
- On accept: col increments. At col=IMG_W-1, col wraps to 0 and row increments.
- win_valid is registered. It is set on the cycle after an accept at (r,c) with r>=K-1 and c>=K-1, i.e. once the shift register has taken that pixel.
  - Same edge: win_row <= r-(K-1), win_col <= c-(K-1).
  - Otherwise win_valid clears next cycle, unless stalled.
  - Accepts with c<K-1 produce no window; those windows would straddle rows.
- Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).
- frame_done coincides with the win_valid of the last window, one cycle after the final accept.
- busy = FILL or RUN.

Optional Feature:
WIN_STALL_EN
- Defined: when win_valid=1 and out_ready=0, the block is stalled.
  - win_valid, win_row and win_col hold.
  - in_ready=0, counters freeze, and a pending DONE transition waits.
  - The stall releases on the cycle out_ready=1.
- Undefined: out_ready is ignored and the block never stalls; the downstream must accept every window.

Test Plan (all with IMG_W=8, IMG_H=8, K=3):
1. Reset, pulse start, then 64 back-to-back pixels of value 0..63 -> exactly 36 win_valid pulses.
   - First pulse is on the cycle after accepting pixel 18, with win_row=0, win_col=0.
   - Last pulse has win_row=5, win_col=5, with frame_done high in that same cycle.
   - busy drops afterwards.
2. Drive in_valid with a 1-on/1-off pattern -> same 36 windows with identical coordinates, and shift_en pulses only on valid cycles.
3. Check column wrap: accepts at pixel indices 24 and 25 (row 3, col 0 and 1) -> no win_valid. The accept at index 26 (row 3, col 2) -> win_row=1, win_col=0.
4. Pulse start during RUN at pixel 30 -> ignored; counters continue and the frame still yields 36 windows.
5. Assert rst after 40 pixels -> next cycle all outputs are 0 and the state is IDLE, with no frame_done. A new start plus 64 pixels -> 36 windows.
6. With WIN_STALL_EN: hold out_ready=0 for 5 cycles when the first window appears -> win_valid, win_row=0 and win_col=0 hold for 5 cycles with in_ready=0. Then it resumes and still yields 36 windows total.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Sequencer for a KxK convolution window shift register: accepts a raster pixel stream,
// tracks row/column and flags complete windows. Optional backpressure via `WIN_STALL_EN.
module conv_window_ctrl #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              shift_en,
    output logic [DATA_W-1:0] pix_out,
    output logic              win_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          stall;
    logic          accept;
    logic          win_hit;
    logic          last_pix;
    logic          fill_end;

`ifdef WIN_STALL_EN
    assign stall = win_valid & ~out_ready;
`else
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign stall = 1'b0;
`endif

    assign busy     = (state == FILL) || (state == RUN);
    assign in_ready = busy & ~stall;
    assign accept   = in_valid & in_ready;
    assign shift_en = accept;
    assign pix_out  = in_data;

    // A window is complete only when the accepted pixel is at least K-1 into both axes,
    // which also excludes windows that would straddle a row boundary.
    assign win_hit  = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign fill_end = (row == ROW_FIRST) && (col == COL_FIRST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!stall) begin
                if (accept && win_hit) begin
                    win_valid <= 1'b1;
                    win_row   <= row - ROW_FIRST;
                    win_col   <= col - COL_FIRST;
                end else begin
                    win_valid <= 1'b0;
                end
            end

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            // DONE holds while a stalled final window is still waiting downstream.
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        state <= FILL;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                FILL: begin
                    frame_done <= 1'b0;
                    if (accept && fill_end) state <= RUN;
                end
                RUN: begin
                    if (accept && last_pix) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        frame_done <= 1'b0;
                    end
                end
                DONE: begin
                    if (!stall) begin
                        state      <= IDLE;
                        frame_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed, table-driven bench for conv_window_ctrl on an 8x8 image with a 3x3 kernel.
// Define WIN_STALL_EN for both bench and RTL to exercise downstream backpressure.
module tb_conv_window_ctrl;

    localparam int DATA_W = 9;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NWIN   = (IMG_W - K + 1) * (IMG_H - K + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              shift_en;
    logic [DATA_W-1:0] pix_out;
    logic              win_valid;
    logic              out_ready;
    logic [2:0]        win_row;
    logic [2:0]        win_col;
    logic              busy;
    logic              frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int exp_wv;
        int exp_r;
        int exp_c;
        int exp_fd;
    } vec_t;

    vec_t vecs[9];

    conv_window_ctrl #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift_en(shift_en), .pix_out(pix_out),
        .win_valid(win_valid), .out_ready(out_ready),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int data, input logic st, input logic ordy);
        in_valid  = v;
        in_data   = DATA_W'(data);
        start     = st;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame();
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_in_ready", in_ready, 1);
    endtask

    // Streams one frame of pixel values 0..NPIX-1 and checks each accept's window result
    // against coordinates derived from the pixel index.
    task automatic sendFrame(input bit gap, input int start_at, input int reset_at, input bit stall_mode);
        int idx = 0;
        int cyc = 0;
        int wins = 0;
        int r, c;
        logic v;
        while (idx < NPIX) begin
            if (cyc > 1000) begin
                checkOutput("frame_timeout", idx, NPIX);
                return;
            end
            if (reset_at >= 0 && idx == reset_at) begin
                rst = 1'b1;
                applyStimulus(1'b0, 0, 1'b0, 1'b1);
                tick();
                rst = 1'b0;
                checkOutput("rst_win_valid", win_valid, 0);
                checkOutput("rst_win_row", win_row, 0);
                checkOutput("rst_win_col", win_col, 0);
                checkOutput("rst_frame_done", frame_done, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_in_ready", in_ready, 0);
                tick();
                checkOutput("rst_no_done", frame_done, 0);
                checkOutput("rst_idle", busy, 0);
                return;
            end
            v = gap ? ((cyc % 2) == 0) : 1'b1;
            applyStimulus(v, idx, (v && idx == start_at), 1'b1);
            #1;
            checkOutput("in_ready", in_ready, 1);
            checkOutput("shift_en", shift_en, int'(v));
            if (v) checkOutput("pix_out", pix_out, idx);
            tick();
            cyc++;
            if (win_valid) wins++;
            if (v) begin
                r = idx / IMG_W;
                c = idx % IMG_W;
                checkOutput("win_valid", win_valid, int'(r >= K-1 && c >= K-1));
                if (r >= K-1 && c >= K-1) begin
                    checkOutput("win_row", win_row, r - (K-1));
                    checkOutput("win_col", win_col, c - (K-1));
                end
                checkOutput("frame_done", frame_done, int'(idx == NPIX-1));
                for (int t = 0; t < 9; t++) begin
                    if (vecs[t].idx == idx) begin
                        checkOutput("vec_win_valid", win_valid, vecs[t].exp_wv);
                        if (vecs[t].exp_wv != 0) begin
                            checkOutput("vec_win_row", win_row, vecs[t].exp_r);
                            checkOutput("vec_win_col", win_col, vecs[t].exp_c);
                        end
                        checkOutput("vec_frame_done", frame_done, vecs[t].exp_fd);
                    end
                end
`ifdef WIN_STALL_EN
                if (stall_mode && idx == 18) begin
                    applyStimulus(1'b1, 19, 1'b0, 1'b0);
                    for (int s = 0; s < 5; s++) begin
                        #1;
                        checkOutput("stall_in_ready", in_ready, 0);
                        checkOutput("stall_shift_en", shift_en, 0);
                        tick();
                        checkOutput("stall_win_valid", win_valid, 1);
                        checkOutput("stall_win_row", win_row, 0);
                        checkOutput("stall_win_col", win_col, 0);
                    end
                end
`endif
                idx++;
            end else begin
                checkOutput("gap_win_valid", win_valid, 0);
            end
        end
        checkOutput("window_count", wins, NWIN);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        tick();
        checkOutput("post_busy", busy, 0);
        checkOutput("post_frame_done", frame_done, 0);
        checkOutput("post_win_valid", win_valid, 0);
        checkOutput("post_in_ready", in_ready, 0);
    endtask

    initial begin
        vecs[0] = '{17, 0, 0, 0, 0};
        vecs[1] = '{18, 1, 0, 0, 0};
        vecs[2] = '{23, 1, 0, 5, 0};
        vecs[3] = '{24, 0, 0, 0, 0};
        vecs[4] = '{25, 0, 0, 0, 0};
        vecs[5] = '{26, 1, 1, 0, 0};
        vecs[6] = '{47, 1, 3, 5, 0};
        vecs[7] = '{62, 1, 5, 4, 0};
        vecs[8] = '{63, 1, 5, 5, 1};

        rst = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_win_valid", win_valid, 0);
        checkOutput("reset_win_row", win_row, 0);
        checkOutput("reset_win_col", win_col, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_shift_en", shift_en, 0);

        $display("[TB] back-to-back frame");
        startFrame();
        sendFrame(1'b0, -1, -1, 1'b0);

        $display("[TB] gapped in_valid frame");
        startFrame();
        sendFrame(1'b1, -1, -1, 1'b0);

        $display("[TB] start pulse during RUN");
        startFrame();
        sendFrame(1'b0, 30, -1, 1'b0);

        $display("[TB] reset mid-frame, then full frame");
        startFrame();
        sendFrame(1'b0, -1, 40, 1'b0);
        startFrame();
        sendFrame(1'b0, -1, -1, 1'b0);

`ifdef WIN_STALL_EN
        $display("[TB] stalled first window");
        startFrame();
        sendFrame(1'b0, -1, -1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
